// File: rtl/paritychk_rx_if.sv
//------------------------------------------------------------------------------
// paritychk_rx_if : serial-in / parallel-out bundle for the parity checker.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface paritychk_rx_if #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
);
   logic              start;
   logic              din;
   logic              din_valid;
   logic [DATA_W-1:0] data_out;
   logic              valid;
   logic              par_err;
   logic              busy;
   logic [CNT_W-1:0]  err_cnt;

   modport master (
      output start, din, din_valid,
      input  data_out, valid, par_err, busy, err_cnt
   );

   modport slave (
      input  start, din, din_valid,
      output data_out, valid, par_err, busy, err_cnt
   );
endinterface

`default_nettype wire

// File: rtl/paritychk_rx.sv
//------------------------------------------------------------------------------
// paritychk_rx : serial even-parity frame receiver, MSB first, parallel output.
// Optional saturating bad-frame counter enabled by macro PARITYCHK_ERR_CNT_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module paritychk_rx #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input wire logic        clk,
   input wire logic        rst,
   paritychk_rx_if.slave   bus
);
   localparam int BCNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_shreg;
   logic [BCNT_W-1:0]   r_bit_cnt;
   logic [DATA_W-1:0]   r_data_out;
   logic                r_valid;
   logic                r_par_err;
   logic                r_busy;

   logic [DATA_W-1:0]   w_shreg_next;
   logic                w_frame_done;
   logic                w_frame_bad;

   // A one-bit frame has nothing to shift along, so the slice is special-cased.
   generate
      if (DATA_W == 1) begin : g_shift_1
         assign w_shreg_next = bus.din;
      end else begin : g_shift_n
         assign w_shreg_next = {r_shreg[DATA_W-2:0], bus.din};
      end
   endgenerate

   assign w_frame_done = (r_state == S_PARITY) && bus.din_valid;
   assign w_frame_bad  = ^{r_shreg, bus.din};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_bit_cnt  <= '0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_par_err  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state   <= S_DATA;
                  r_bit_cnt <= '0;
                  r_busy    <= 1'b1;
               end
            end
            S_DATA: begin
               if (bus.din_valid) begin
                  r_shreg   <= w_shreg_next;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == BCNT_W'(DATA_W - 1)) begin
                     r_state <= S_PARITY;
                  end
               end
            end
            S_PARITY: begin
               if (bus.din_valid) begin
                  r_data_out <= r_shreg;
                  r_par_err  <= w_frame_bad;
                  r_valid    <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef PARITYCHK_ERR_CNT_EN
   logic [CNT_W-1:0] r_err_cnt;

   // Updated on the same edge as par_err so the count is current during valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (w_frame_done && w_frame_bad && (r_err_cnt != {CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign bus.err_cnt = r_err_cnt;
`else
   assign bus.err_cnt = '0;
`endif

   assign bus.data_out = r_data_out;
   assign bus.valid    = r_valid;
   assign bus.par_err  = r_par_err;
   assign bus.busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_paritychk_rx.sv
//------------------------------------------------------------------------------
// tb_paritychk_rx : directed bench for paritychk_rx (DATA_W=4, CNT_W=8 and 2).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_paritychk_rx;
`ifdef PARITYCHK_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   exp8   = 0;
   int   exp2   = 0;

   always #5 clk = ~clk;

   paritychk_rx_if #(.DATA_W(4), .CNT_W(8)) bus ();
   paritychk_rx_if #(.DATA_W(4), .CNT_W(2)) bus2 ();

   assign bus2.start     = bus.start;
   assign bus2.din       = bus.din;
   assign bus2.din_valid = bus.din_valid;

   paritychk_rx #(.DATA_W(4), .CNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   paritychk_rx #(.DATA_W(4), .CNT_W(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic frame(input logic [3:0] d, input logic p, input int gap,
                        input bit mid_start, input bit dv_on_start);
      logic bad;
      bus.start     = 1'b1;
      bus.din_valid = dv_on_start;
      bus.din       = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.din_valid = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         bus.din_valid = 1'b1;
         bus.din       = d[3-i];
         tick();
         bus.din_valid = 1'b0;
         bus.din       = ~bus.din;
         chk("no_early_valid", 32'(bus.valid), 32'd0);
         for (int g = 0; g < gap; g++) begin
            bus.start = mid_start;
            tick();
            bus.start = 1'b0;
            chk("busy_in_gap", 32'(bus.busy), 32'd1);
         end
      end
      bus.din_valid = 1'b1;
      bus.din       = p;
      tick();
      bus.din_valid = 1'b0;
      bad = ^{d, p};
      if (bad && CNT_EN) begin
         if (exp8 < 255) exp8++;
         if (exp2 < 3)   exp2++;
      end
      chk("valid_pulse", 32'(bus.valid), 32'd1);
      chk("data_out", 32'(bus.data_out), 32'(d));
      chk("par_err", 32'(bus.par_err), 32'(bad));
      chk("busy_on_valid", 32'(bus.busy), 32'd0);
      chk("err_cnt8", 32'(bus.err_cnt), 32'(exp8));
      chk("err_cnt2", 32'(bus2.err_cnt), 32'(exp2));
      chk("par_err_cnt2", 32'(bus2.par_err), 32'(bad));
      tick();
      chk("valid_one_cycle", 32'(bus.valid), 32'd0);
      chk("data_hold", 32'(bus.data_out), 32'(d));
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.din       = 1'b0;
      bus.din_valid = 1'b0;
      repeat (2) tick();
      chk("rst_data_out", 32'(bus.data_out), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_par_err", 32'(bus.par_err), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // 1: good frame; 2: bad parity
      frame(4'b1011, 1'b1, 0, 1'b0, 1'b0);
      frame(4'b1011, 1'b0, 0, 1'b0, 1'b0);
      // 3: gaps of 3 idle cycles with start pulsed mid-frame
      frame(4'b1011, 1'b1, 3, 1'b1, 1'b0);
      // start coinciding with din_valid in IDLE must not shift din
      frame(4'b0101, 1'b0, 0, 1'b0, 1'b1);

      // 4: abort after 2 data bits
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.din_valid = 1'b1;
      bus.din = 1'b1;
      tick();
      tick();
      bus.din_valid = 1'b0;
      rst = 1'b1;
      #2;
      exp8 = 0;
      exp2 = 0;
      chk("abort_data_out", 32'(bus.data_out), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_par_err", 32'(bus.par_err), 32'd0);
      chk("abort_err_cnt", 32'(bus.err_cnt), 32'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("abort_no_valid", 32'(bus.valid), 32'd0);
      end
      frame(4'b0110, 1'b0, 0, 1'b0, 1'b0);

      // 5: saturation of the narrow counter
      for (int k = 0; k < 5; k++) begin
         frame(4'b1011, 1'b0, 0, 1'b0, 1'b0);
      end

      // 6: every data value with correct and inverted parity
      for (int v = 0; v < 16; v++) begin
         logic [3:0] dv;
         dv = 4'(v);
         frame(dv, ^dv, 0, 1'b0, 1'b0);
         frame(dv, ~(^dv), 0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
